// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: key-length derivations, rcon step,
// S-box table and the expander state encoding.
package aes_key_pkg;

   localparam int KEY_LEN_128 = 128;
   localparam int KEY_LEN_192 = 192;
   localparam int KEY_LEN_256 = 256;

   function automatic int nk_of(input int key_len);
      case (key_len)
         KEY_LEN_192: return 6;
         KEY_LEN_256: return 8;
         default:     return 4;
      endcase
   endfunction

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   function automatic int nw_of(input int nr);
      return 4 * (nr + 1);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } keyexp_state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit schedule word.
module aes_sub_word
   import aes_key_pkg::*;
(
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   assign word_out = {SBOX[word_in[31:24]],
                      SBOX[word_in[23:16]],
                      SBOX[word_in[15:8]],
                      SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule, one word per cycle, registered round-key read.
// Optional AES_KEYGEN_REV_READ_EN adds rd_rev for decryption-order reads.
module aes_key_expander
   import aes_key_pkg::*;
#(
   parameter int KEY_LEN = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_LEN-1:0] key_in,
   output logic               busy,
   output logic               done,
   input  logic [3:0]         rd_addr,
   input  logic               rd_en,
`ifdef AES_KEYGEN_REV_READ_EN
   input  logic               rd_rev,
`endif
   output logic [127:0]       rd_key,
   output logic               rd_valid,
   output logic               rd_err
);

   localparam int NK = nk_of(KEY_LEN);
   localparam int NR = nr_of(NK);
   localparam int NW = nw_of(NR);

   localparam logic [5:0] I_LAST   = 6'(NW - 1);
   localparam logic [5:0] I_FIRST  = 6'(NK);
   localparam logic [2:0] CNT_LAST = 3'(NK - 1);
   localparam logic [3:0] NR_A     = 4'(NR);

   if (KEY_LEN != KEY_LEN_128 && KEY_LEN != KEY_LEN_192 &&
       KEY_LEN != KEY_LEN_256) begin : g_bad_len
      $error("aes_key_expander: KEY_LEN must be 128, 192 or 256");
   end

   keyexp_state_t state_q, state_d;

   logic [5:0]  idx_q;
   logic [2:0]  cnt_q;
   logic [7:0]  rcon_q;
   logic [31:0] win_q [NK];
   logic [31:0] w_q   [NW];

   logic        start_acc;
   logic [31:0] prev_w;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] new_w;

   assign start_acc = start && (state_q != EXPAND);
   assign busy      = (state_q == EXPAND);
   assign done      = (state_q == READY);

   // Window holds w[i-NK] .. w[i-1], so the recurrence needs no store muxing.
   assign prev_w = win_q[NK-1];
   assign sub_in = (cnt_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   aes_sub_word u_sub (
      .word_in  (sub_in),
      .word_out (sub_out)
   );

   always_comb begin
      new_w = win_q[0] ^ prev_w;
      unique case (1'b1)
         (cnt_q == 3'd0):
            new_w = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
         (NK == 8 && cnt_q == 3'd4):
            new_w = win_q[0] ^ sub_out;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, READY: if (start_acc) state_d = EXPAND;
         EXPAND:      if (idx_q == I_LAST) state_d = READY;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         rcon_q <= '0;
         for (int j = 0; j < NK; j++) win_q[j] <= '0;
         for (int j = 0; j < NW; j++) w_q[j]   <= '0;
      end else if (start_acc) begin
         idx_q  <= I_FIRST;
         cnt_q  <= '0;
         rcon_q <= 8'h01;
         for (int j = 0; j < NK; j++) begin
            win_q[j] <= key_in[KEY_LEN-1-32*j -: 32];
            w_q[j]   <= key_in[KEY_LEN-1-32*j -: 32];
         end
      end else if (state_q == EXPAND) begin
         w_q[idx_q] <= new_w;
         for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
         win_q[NK-1] <= new_w;
         idx_q <= idx_q + 6'd1;
         cnt_q <= (cnt_q == CNT_LAST) ? 3'd0 : cnt_q + 3'd1;
         if (cnt_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
   end

   logic [3:0] rd_round;
   logic [5:0] rd_base;
   logic       rd_ok;

`ifdef AES_KEYGEN_REV_READ_EN
   assign rd_round = rd_rev ? (NR_A - rd_addr) : rd_addr;
`else
   assign rd_round = rd_addr;
`endif
   assign rd_base = {rd_round, 2'b00};

   // A start accepted this cycle invalidates the schedule being read.
   assign rd_ok = rd_en && (state_q == READY) && !start_acc &&
                  (rd_addr <= NR_A);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_key   <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         rd_err   <= rd_en && !rd_ok;
         if (rd_ok)
            rd_key <= {w_q[rd_base], w_q[rd_base + 6'd1],
                       w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: one instance per key length, read scoreboard.
module tb_aes_key_expander;

   localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [191:0] K192   =
      192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [127:0] R0_192 = 128'h8e73b0f7da0e6452c810f32b809079e5;
   localparam logic [127:0] R1_192 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
   localparam logic [127:0] R12    = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [255:0] K256   =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R1_256 = 128'h1f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R2_256 = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [127:0] R14    = 128'hfe4890d1e6188d0b046df344706c631e;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   start;
   logic [2:0]   rd_en;
   logic [3:0]   rd_addr;
   logic         rd_rev;
   logic [2:0]   busy, done, rd_valid, rd_err;
   logic [127:0] rd_key [3];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   aes_key_expander #(.KEY_LEN(128)) u_k128 (
      .clk(clk), .rst(rst), .start(start[0]), .key_in(K128),
      .busy(busy[0]), .done(done[0]), .rd_addr(rd_addr), .rd_en(rd_en[0]),
`ifdef AES_KEYGEN_REV_READ_EN
      .rd_rev(rd_rev),
`endif
      .rd_key(rd_key[0]), .rd_valid(rd_valid[0]), .rd_err(rd_err[0])
   );

   aes_key_expander #(.KEY_LEN(192)) u_k192 (
      .clk(clk), .rst(rst), .start(start[1]), .key_in(K192),
      .busy(busy[1]), .done(done[1]), .rd_addr(rd_addr), .rd_en(rd_en[1]),
`ifdef AES_KEYGEN_REV_READ_EN
      .rd_rev(rd_rev),
`endif
      .rd_key(rd_key[1]), .rd_valid(rd_valid[1]), .rd_err(rd_err[1])
   );

   aes_key_expander #(.KEY_LEN(256)) u_k256 (
      .clk(clk), .rst(rst), .start(start[2]), .key_in(K256),
      .busy(busy[2]), .done(done[2]), .rd_addr(rd_addr), .rd_en(rd_en[2]),
`ifdef AES_KEYGEN_REV_READ_EN
      .rd_rev(rd_rev),
`endif
      .rd_key(rd_key[2]), .rd_valid(rd_valid[2]), .rd_err(rd_err[2])
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   typedef struct {
      int           inst;
      int           due;
      logic         v;
      logic         e;
      logic [127:0] k;
      string        tag;
   } exp_t;

   exp_t         sbq [$];
   logic [127:0] held [3];
   exp_t         mx;

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         mx = sbq.pop_front();
         chk({mx.tag, "_valid"}, rd_valid[mx.inst], mx.v);
         chk({mx.tag, "_err"},   rd_err[mx.inst],   mx.e);
         chk({mx.tag, "_key"},   rd_key[mx.inst],   mx.k);
      end
   end

   task automatic do_read(input int inst, input logic [3:0] a,
                          input logic rev, input logic ok,
                          input logic [127:0] k, input string tag,
                          input logic with_start);
      exp_t x;
      @(negedge clk);
      rd_addr     = a;
      rd_rev      = rev;
      rd_en[inst] = 1'b1;
      if (with_start) start[inst] = 1'b1;
      x.inst = inst;
      x.due  = cyc + 1;
      x.v    = ok;
      x.e    = !ok;
      x.k    = ok ? k : held[inst];
      x.tag  = tag;
      if (ok) held[inst] = k;
      sbq.push_back(x);
      @(posedge clk);
      @(negedge clk);
      rd_en[inst] = 1'b0;
      start[inst] = 1'b0;
      rd_rev      = 1'b0;
   endtask

   task automatic start_exp(input int inst, input int nexp,
                            input int restart_at, input string tag);
      int   n    = 0;
      logic seen = 1'b0;
      @(negedge clk);
      start[inst] = 1'b1;
      while (n < 200 && !seen) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            start[inst] = 1'b0;
            chk({tag, "_busy"},    busy[inst], 1'b1);
            chk({tag, "_done_lo"}, done[inst], 1'b0);
         end
         if (restart_at > 0 && n == restart_at)     start[inst] = 1'b1;
         if (restart_at > 0 && n == restart_at + 1) start[inst] = 1'b0;
         seen = done[inst];
      end
      chk({tag, "_latency"},  n,          nexp);
      chk({tag, "_busy_end"}, busy[inst], 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = '0;
      rd_en   = '0;
      rd_addr = '0;
      rd_rev  = 1'b0;
      for (int j = 0; j < 3; j++) held[j] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int j = 0; j < 3; j++) begin
         chk($sformatf("rst_busy%0d", j),  busy[j],     1'b0);
         chk($sformatf("rst_done%0d", j),  done[j],     1'b0);
         chk($sformatf("rst_key%0d", j),   rd_key[j],   '0);
         chk($sformatf("rst_valid%0d", j), rd_valid[j], 1'b0);
         chk($sformatf("rst_err%0d", j),   rd_err[j],   1'b0);
      end

      do_read(0, 4'd0, 1'b0, 1'b0, '0, "rd_idle", 1'b0);

      start_exp(0, 41, 0, "s128");
      do_read(0, 4'd10, 1'b0, 1'b1, R10,    "r128_10", 1'b0);
      do_read(0, 4'd0,  1'b0, 1'b1, K128,   "r128_0",  1'b0);
      do_read(0, 4'd1,  1'b0, 1'b1, R1_128, "r128_1",  1'b0);
      do_read(0, 4'd11, 1'b0, 1'b0, '0,     "r128_11", 1'b0);

      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      do_read(0, 4'd2, 1'b0, 1'b0, '0, "rd_busy", 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 3; j++) held[j] = '0;
      chk("abort_busy",  busy[0],     1'b0);
      chk("abort_done",  done[0],     1'b0);
      chk("abort_key",   rd_key[0],   '0);
      chk("abort_valid", rd_valid[0], 1'b0);

      start_exp(0, 41, 0, "restart");
      do_read(0, 4'd10, 1'b0, 1'b1, R10, "rs_10", 1'b0);

      start_exp(0, 41, 5, "dbl");
      do_read(0, 4'd10, 1'b0, 1'b1, R10,    "dbl_10", 1'b0);
      do_read(0, 4'd1,  1'b0, 1'b1, R1_128, "dbl_1",  1'b0);

      do_read(0, 4'd3, 1'b0, 1'b0, '0, "rd_start", 1'b1);
      for (int n = 0; n < 100 && !done[0]; n++) @(negedge clk);
      chk("rd_start_done", done[0], 1'b1);
      do_read(0, 4'd10, 1'b0, 1'b1, R10, "post_10", 1'b0);

`ifdef AES_KEYGEN_REV_READ_EN
      do_read(0, 4'd0,  1'b1, 1'b1, R10,    "rev_0",  1'b0);
      do_read(0, 4'd9,  1'b1, 1'b1, R1_128, "rev_9",  1'b0);
      do_read(0, 4'd10, 1'b1, 1'b1, K128,   "rev_10", 1'b0);
      do_read(0, 4'd11, 1'b1, 1'b0, '0,     "rev_11", 1'b0);
`endif

      start_exp(1, 47, 0, "s192");
      do_read(1, 4'd12, 1'b0, 1'b1, R12,    "r192_12", 1'b0);
      do_read(1, 4'd0,  1'b0, 1'b1, R0_192, "r192_0",  1'b0);
      do_read(1, 4'd1,  1'b0, 1'b1, R1_192, "r192_1",  1'b0);
      do_read(1, 4'd13, 1'b0, 1'b0, '0,     "r192_13", 1'b0);

      start_exp(2, 53, 0, "s256");
      do_read(2, 4'd14, 1'b0, 1'b1, R14,    "r256_14", 1'b0);
      do_read(2, 4'd1,  1'b0, 1'b1, R1_256, "r256_1",  1'b0);
      do_read(2, 4'd2,  1'b0, 1'b1, R2_256, "r256_2",  1'b0);
      do_read(2, 4'd15, 1'b0, 1'b0, '0,     "r256_15", 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drained", 128'(sbq.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
